// File: rtl/mem_pkg.sv
// Shared definitions for the line-memory subsystem: default widths, arbiter
// state encodings and the request opcode type.
package mem_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // Client index of a two-way one-hot grant (bit 1 set means client 1).
    function automatic logic onehot_to_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between two line clients, the arbiter and the memory.
// The arbiter uses the slave view; the environment drives through master.
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              c0_read;
    logic              c0_write;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic [DATA_W-1:0] c0_rdata;
    logic              c0_ready;

    logic              c1_read;
    logic              c1_write;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic [DATA_W-1:0] c1_rdata;
    logic              c1_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  c0_read, c0_write, c0_addr, c0_wdata,
        input  c1_read, c1_write, c1_addr, c1_wdata,
        input  mem_rdata, mem_ready,
        output c0_rdata, c0_ready, c1_rdata, c1_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output c0_read, c0_write, c0_addr, c0_wdata,
        output c1_read, c1_write, c1_addr, c1_wdata,
        output mem_rdata, mem_ready,
        input  c0_rdata, c0_ready, c1_rdata, c1_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant: on contention the client not granted last wins.
// Purely combinational; the caller owns the last-grant register.
module rr_arbiter (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client line arbiter in front of a single-ported memory. One transaction
// is in flight at a time; each completion is reported by a one-cycle ready.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    mem_arbiter_if.slave bus
);

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_owner;
    mem_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c0_rdata;
    logic [DATA_W-1:0] r_c1_rdata;
    logic              r_c0_ready;
    logic              r_c1_ready;

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_gnt_idx;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_in_wait;

    // A client with both read and write raised is taken as a write.
    assign w_req[0]    = bus.c0_read | bus.c0_write;
    assign w_req[1]    = bus.c1_read | bus.c1_write;
    assign w_gnt_idx   = onehot_to_idx(w_grant);
    assign w_sel_write = w_gnt_idx ? bus.c1_write : bus.c0_write;
    assign w_sel_addr  = w_gnt_idx ? bus.c1_addr  : bus.c0_addr;
    assign w_sel_wdata = w_gnt_idx ? bus.c1_wdata : bus.c0_wdata;

    rr_arbiter u_rr (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_c0_rdata   <= '0;
            r_c1_rdata   <= '0;
            r_c0_ready   <= 1'b0;
            r_c1_ready   <= 1'b0;
        end else begin
            r_c0_ready <= 1'b0;
            r_c1_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_state      <= ST_WAIT;
                        r_owner      <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_op         <= w_sel_write ? OP_WRITE : OP_READ;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                    end
                end
                ST_WAIT: begin
                    // Completion is registered, so ready shows up in RESP.
                    if (bus.mem_ready) begin
                        r_state <= ST_RESP;
                        if (r_op == OP_READ) begin
                            if (r_owner) r_c1_rdata <= bus.mem_rdata;
                            else         r_c0_rdata <= bus.mem_rdata;
                        end
                        if (r_owner) r_c1_ready <= 1'b1;
                        else         r_c0_ready <= 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Requests drop combinationally in the ready cycle and on reset.
    assign w_in_wait     = (r_state == ST_WAIT);
    assign bus.mem_read  = w_in_wait && (r_op == OP_READ)  && !bus.mem_ready;
    assign bus.mem_write = w_in_wait && (r_op == OP_WRITE) && !bus.mem_ready;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.c0_rdata  = r_c0_rdata;
    assign bus.c1_rdata  = r_c1_rdata;
    assign bus.c0_ready  = r_c0_ready;
    assign bus.c1_ready  = r_c1_ready;

    a_single_ready: assert property (
        @(posedge clk) disable iff (!proc_reset_n) !(r_c0_ready && r_c1_ready)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level client/memory model
// with a round-robin ordering rule and per-client read-line expectations.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;

    logic clk = 1'b0;
    logic proc_reset_n;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Client stimulus
    logic          c_rd[2];
    logic          c_wr[2];
    logic [AW-1:0] c_addr[2];
    logic [DW-1:0] c_wd[2];
    int            gap[2];
    bit            got_ready[2];
    bit            auto_gen = 0;
    int            gap_max  = 0;

    // Memory model
    bit            m_busy;
    int            m_cnt;
    int            m_lat = -1;
    bit            m_fix = 0;
    logic [DW-1:0] m_fixval;
    bit            m_owner;
    bit            m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;

    // Reference state
    bit            sched;
    bit            sched_owner;
    bit            sched_write;
    logic [DW-1:0] sched_data;
    logic [DW-1:0] exp_rdata[2];
    bit            mdl_last;
    bit            prev_pend[2];
    int            n_ready[2];
    int            ready_log[$];

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            c_rd[i] = 1'b0; c_wr[i] = 1'b0; got_ready[i] = 1'b0; gap[i] = 0;
            exp_rdata[i] = '0; prev_pend[i] = 1'b0;
        end
        m_busy = 1'b0; sched = 1'b0; mdl_last = 1'b1;
        bus.mem_ready = 1'b0;
    endtask

    task automatic apply_clients();
        bus.c0_read = c_rd[0]; bus.c0_write = c_wr[0]; bus.c0_addr = c_addr[0]; bus.c0_wdata = c_wd[0];
        bus.c1_read = c_rd[1]; bus.c1_write = c_wr[1]; bus.c1_addr = c_addr[1]; bus.c1_wdata = c_wd[1];
    endtask

    task automatic drive_phase();
        for (int i = 0; i < 2; i++) begin
            if (got_ready[i]) begin
                c_rd[i] = 1'b0; c_wr[i] = 1'b0; got_ready[i] = 1'b0;
                gap[i] = $urandom_range(0, gap_max);
            end
            if (auto_gen && !(c_rd[i] || c_wr[i])) begin
                if (gap[i] <= 0) begin
                    c_wr[i]   = 1'($urandom_range(0, 1));
                    c_rd[i]   = !c_wr[i];
                    c_addr[i] = AW'($urandom);
                    c_wd[i]   = rand_line();
                end else begin
                    gap[i]--;
                end
            end
        end
        apply_clients();
        bus.mem_ready = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = m_fix ? m_fixval : rand_line();
            end else begin
                m_cnt--;
            end
        end
    endtask

    task automatic sample_phase();
        bit owner;
        if (sched && !sched_write) exp_rdata[sched_owner] = sched_data;
        check_eq("c0_ready", bus.c0_ready, sched && !sched_owner);
        check_eq("c1_ready", bus.c1_ready, sched && sched_owner);
        sched = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && bus.c0_ready) || (i == 1 && bus.c1_ready)) begin
                got_ready[i] = 1'b1; n_ready[i]++; ready_log.push_back(i);
            end
        end
        check_eq("c0_rdata", bus.c0_rdata, exp_rdata[0]);
        check_eq("c1_rdata", bus.c1_rdata, exp_rdata[1]);

        if (bus.mem_ready && m_busy) begin
            check_eq("mem_req_in_ready_cycle", {bus.mem_read, bus.mem_write}, 2'b00);
            sched = 1'b1; sched_owner = m_owner; sched_write = m_write;
            sched_data = bus.mem_rdata; m_busy = 1'b0;
        end else if (m_busy) begin
            check_eq("mem_read_wait", bus.mem_read, !m_write);
            check_eq("mem_write_wait", bus.mem_write, m_write);
            check_eq("mem_addr_wait", bus.mem_addr, m_addr);
            check_eq("mem_wdata_wait", bus.mem_wdata, m_wd);
        end else if (bus.mem_read || bus.mem_write) begin
            if (!prev_pend[0] && !prev_pend[1]) begin
                check_eq("mem_req_without_client", {bus.mem_read, bus.mem_write}, 2'b00);
            end else begin
                owner    = (prev_pend[0] && prev_pend[1]) ? !mdl_last : prev_pend[1];
                mdl_last = owner;
                m_owner  = owner;
                m_write  = c_wr[owner];
                m_addr   = c_addr[owner];
                m_wd     = c_wd[owner];
                check_eq("mem_write_start", bus.mem_write, m_write);
                check_eq("mem_read_start", bus.mem_read, !m_write);
                check_eq("mem_addr_start", bus.mem_addr, m_addr);
                check_eq("mem_wdata_start", bus.mem_wdata, m_wd);
                m_busy = 1'b1;
                m_cnt  = (m_lat < 0) ? $urandom_range(0, 3) : m_lat;
            end
        end
        for (int i = 0; i < 2; i++) prev_pend[i] = c_rd[i] || c_wr[i];
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive_phase();
        @(negedge clk);
        sample_phase();
    endtask

    task automatic run_until(input int target, input int budget);
        int cyc = 0;
        while ((n_ready[0] + n_ready[1]) < target && cyc < budget) begin
            step();
            cyc++;
        end
        if ((n_ready[0] + n_ready[1]) < target)
            check_eq("ready_timeout", n_ready[0] + n_ready[1], target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset_n = 1'b0;
        model_clear();
        apply_clients();
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (proc_reset_n === 1'b1) begin
            a_c0_rw: assert (!(bus.c0_read && bus.c0_write)) else $error("illegal c0 read+write");
            a_c1_rw: assert (!(bus.c1_read && bus.c1_write)) else $error("illegal c1 read+write");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, tot, s, first, c1_before;
        logic [DW-1:0] pat_a5, d1, d2;

        for (int i = 0; i < 2; i++) begin
            c_addr[i] = '0; c_wd[i] = '0; n_ready[i] = 0;
        end
        bus.mem_rdata = '0;
        proc_reset_n  = 1'b0;
        model_clear();
        apply_clients();

        // Reset values
        #12;
        check_eq("rst_c0_rdata", bus.c0_rdata, '0);
        check_eq("rst_c1_rdata", bus.c1_rdata, '0);
        check_eq("rst_ready", {bus.c0_ready, bus.c1_ready}, 2'b00);
        check_eq("rst_mem_req", {bus.mem_read, bus.mem_write}, 2'b00);
        check_eq("rst_mem_addr", bus.mem_addr, '0);
        check_eq("rst_mem_wdata", bus.mem_wdata, '0);
        @(negedge clk);
        proc_reset_n = 1'b1;

        // Single client-0 read, fixed pattern, three WAIT cycles
        pat_a5 = {16{8'hA5}};
        m_fix = 1; m_fixval = pat_a5; m_lat = 1;
        c_rd[0] = 1'b1; c_addr[0] = AW'(28'h0000010);
        base = n_ready[0] + n_ready[1];
        run_until(base + 1, 30);
        check_eq("r029_c0_rdata", bus.c0_rdata, pat_a5);
        check_eq("r029_c0_count", n_ready[0], 1);
        check_eq("r029_c1_count", n_ready[1], 0);

        // Simultaneous c0 read / c1 write right after reset
        do_reset();
        m_fix = 0; m_lat = -1;
        c_rd[0] = 1'b1; c_addr[0] = AW'($urandom);
        c_wr[1] = 1'b1; c_addr[1] = AW'($urandom); c_wd[1] = rand_line();
        base = n_ready[0] + n_ready[1];
        s = ready_log.size();
        run_until(base + 2, 40);
        check_eq("r030_total", n_ready[0] + n_ready[1], base + 2);
        if (ready_log.size() >= s + 2) begin
            check_eq("r030_first", ready_log[s], 0);
            check_eq("r030_second", ready_log[s+1], 1);
        end
        step(); step();

        // c1 read, write, read: write leaves rdata untouched
        m_fix = 1;
        d1 = rand_line(); d2 = ~d1;
        m_fixval = d1; c_rd[1] = 1'b1; c_addr[1] = AW'($urandom);
        tot = n_ready[0] + n_ready[1];
        run_until(tot + 1, 30);
        check_eq("r032_read1", bus.c1_rdata, d1);
        step();
        m_fixval = d2; c_wr[1] = 1'b1; c_addr[1] = AW'($urandom); c_wd[1] = rand_line();
        run_until(tot + 2, 30);
        check_eq("r032_after_write", bus.c1_rdata, d1);
        step();
        c_rd[1] = 1'b1; c_addr[1] = AW'($urandom);
        run_until(tot + 3, 30);
        check_eq("r032_read2", bus.c1_rdata, d2);
        step();

        // Reset in the middle of a WAIT
        m_fix = 0; m_lat = 3;
        c_rd[0] = 1'b1; c_addr[0] = AW'($urandom);
        for (int k = 0; k < 20 && !m_busy; k++) step();
        check_eq("r033_in_wait", bus.mem_read, 1'b1);
        tot = n_ready[0] + n_ready[1];
        proc_reset_n = 1'b0;
        #1;
        check_eq("r033_mem_read_drop", bus.mem_read, 1'b0);
        check_eq("r033_no_ready", {bus.c0_ready, bus.c1_ready}, 2'b00);
        model_clear();
        apply_clients();
        repeat (2) begin
            @(negedge clk);
            check_eq("r033_ready_in_reset", {bus.c0_ready, bus.c1_ready}, 2'b00);
        end
        proc_reset_n = 1'b1;
        step(); step();
        check_eq("r033_no_ready_count", n_ready[0] + n_ready[1], tot);
        m_lat = -1;
        c_rd[0] = 1'b1; c_addr[0] = AW'($urandom);
        run_until(tot + 1, 30);
        check_eq("r033_recover", n_ready[0], 1 + (n_ready[0] - 1));

        // mem_ready already high in the first WAIT cycle
        do_reset();
        d1 = rand_line();
        @(posedge clk); #1;
        bus.mem_ready = 1'b1; bus.mem_rdata = d1;
        bus.c0_read = 1'b1; bus.c0_addr = AW'($urandom);
        @(negedge clk);
        check_eq("r034_t0_ready", bus.c0_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("r034_mem_read_ready_cycle", bus.mem_read, 1'b0);
        check_eq("r034_t1_ready", bus.c0_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("r034_t2_ready", bus.c0_ready, 1'b1);
        check_eq("r034_t2_rdata", bus.c0_rdata, d1);
        @(posedge clk); #1;
        bus.c0_read = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("r034_t3_ready", bus.c0_ready, 1'b0);
        exp_rdata[0] = d1; mdl_last = 1'b0;
        for (int i = 0; i < 2; i++) prev_pend[i] = 1'b0;

        // Continuous contention alternates grants
        auto_gen = 1; gap_max = 0; m_lat = -1;
        gap[0] = 0; gap[1] = 0;
        first = !mdl_last;
        s = ready_log.size();
        tot = n_ready[0] + n_ready[1];
        run_until(tot + 6, 80);
        if (ready_log.size() >= s + 6) begin
            for (int k = 0; k < 6; k++)
                check_eq("r031_alternate", ready_log[s+k], first ^ (k & 1));
        end

        // Random traffic with idle gaps
        gap_max = 3;
        repeat (1500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, SHALL set the block-address width.
REQ-002 Parameter DATA_W, default 128, SHALL set the line-data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 proc_reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 cN_read, cN_write  input  1 each (N=0,1)  SHALL be the per-client line read and write requests, held until cN_ready.
REQ-006 cN_addr  input  ADDR_W  SHALL be the client block address.
REQ-007 cN_wdata  input  DATA_W  SHALL be the client write line.
REQ-008 cN_rdata  output  DATA_W  SHALL be the registered read line returned to the client.
REQ-009 cN_ready  output  1  SHALL be a one-cycle completion pulse to the client.
REQ-010 mem_read, mem_write  output  1 each  SHALL be the memory requests.
REQ-011 mem_addr  output  ADDR_W  SHALL be the memory address; mem_wdata  output  DATA_W  SHALL be the memory write line.
REQ-012 mem_rdata  input  DATA_W  SHALL be the memory read line; mem_ready  input  1  SHALL mark memory completion.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 IDLE: if any client request is active, SHALL grant one client, latch its op, addr and wdata into registers, and go to WAIT next cycle; otherwise stay in IDLE.
REQ-015 Grant SHALL be round-robin: on contention the client not granted last wins; last_grant resets to 1, so client 0 wins the first contention.
REQ-016 A client with both read and write asserted SHALL be served as a write; this case is illegal and a bench assertion SHALL flag it.
REQ-017 WAIT: mem_read/mem_write SHALL equal the latched op gated by ~mem_ready, both low in the mem_ready cycle; mem_addr and mem_wdata SHALL be driven from the latched registers.
REQ-018 WAIT with mem_ready=1: SHALL capture mem_rdata (reads only) into the granted client's cN_rdata and go to RESP.
REQ-019 RESP: SHALL assert the granted cN_ready for exactly one cycle, then return to IDLE; requests are not sampled in RESP.
REQ-020 Minimum latency, request to cN_ready: 2 cycles + memory wait; a request seen in IDLE at cycle t with mem_ready at t+1 gives cN_ready at t+2.
REQ-021 cN_rdata SHALL hold its value until that client's next read completes; writes SHALL NOT modify cN_rdata.
REQ-022 A request withdrawn during WAIT SHALL still complete, with cN_ready pulsed; the arbiter does not abort.
REQ-023 Outside WAIT, mem_read and mem_write SHALL be 0; mem_addr and mem_wdata SHALL hold their last latched values.
REQ-024 At most one memory transaction SHALL be outstanding; cN_ready SHALL never be asserted for both clients in the same cycle.

Reset
REQ-025 proc_reset_n=0 SHALL immediately force: state IDLE, last_grant=1, all latched registers 0, cN_rdata 0, cN_ready 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0.
REQ-026 Reset mid-transaction SHALL drop the transaction, with no cN_ready issued; first arbitration SHALL occur in the first IDLE cycle after release.

Structure
REQ-027 State encodings and the default widths ADDR_W/DATA_W SHALL live in a shared package, mem_pkg, also used by the caches and the memory model.
REQ-028 Grant selection SHALL be a sub-module, rr_arbiter: 2 requests, last_grant in, one-hot grant out, purely combinational.

Verification
REQ-029 c0_read, addr 0x0000010; memory returns 0xA5..A5 after 3 cycles -> c0_ready is one pulse, c0_rdata=0xA5..A5, c1_ready stays 0.
REQ-030 c0_read and c1_write asserted in the same cycle after reset -> c0 served first, then c1; mem_write seen with c1_addr/c1_wdata; exactly two ready pulses.
REQ-031 Both clients request continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-032 c1_write, then c1_read -> c1_rdata stays unchanged through the write and updates only on the read.
REQ-033 proc_reset_n pulled low during WAIT -> mem_read drops in the same cycle; no cN_ready; the next request completes normally.
REQ-034 mem_ready in the first WAIT cycle -> cN_ready exactly 2 cycles after the request; mem_read is high for 0 cycles in the ready cycle.
